// File: rtl/device_bridge_pkg.sv
// Shared types and widths for the simulation device-helper bridge.
package device_bridge_pkg;

    localparam int DEV_DATA_W = 32;
    localparam int IN_DATA_W  = 64;
    localparam int DEV_MASK_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_LO = 3'd1,
        CAPT_LO  = 3'd2,
        ISSUE_HI = 3'd3,
        CAPT_HI  = 3'd4,
        RESP     = 3'd5
    } dev_bridge_state_e;

endpackage

// File: rtl/device_req_bridge.sv
// Splits one 64-bit uncached MMIO request into up to two 32-bit device
// transactions and returns a single 64-bit response.
module device_req_bridge
    import device_bridge_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h4000_0000,
    parameter logic [31:0] SIZE = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wen,
    input  logic [31:0]           in_addr,
    input  logic [IN_DATA_W-1:0]  in_wdata,
    input  logic [7:0]            in_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IN_DATA_W-1:0]  out_rdata,
    output logic                  out_err,
    output logic                  dev_req_valid,
    output logic                  dev_req_wen,
    output logic [31:0]           dev_req_addr,
    output logic [DEV_DATA_W-1:0] dev_req_wdata,
    output logic [DEV_MASK_W-1:0] dev_req_wmask,
    input  logic [DEV_DATA_W-1:0] dev_resp_rdata
);

    dev_bridge_state_e     state_q, state_d;
    logic                  wen_q, wen_d;
    logic [31:0]           addr_q, addr_d;
    logic [IN_DATA_W-1:0]  wdata_q, wdata_d;
    logic [7:0]            mask_q, mask_d;
    logic [IN_DATA_W-1:0]  rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  dvld_q, dvld_d;
    logic                  dwen_q, dwen_d;
    logic [31:0]           daddr_q, daddr_d;
    logic [DEV_DATA_W-1:0] dwdata_q, dwdata_d;
    logic [DEV_MASK_W-1:0] dmask_q, dmask_d;

    logic [31:0] req_addr;
    logic        in_range;
    logic        unused_addr_lsbs;

    assign req_addr         = {in_addr[31:3], 3'b000};
    // Unsigned wrap makes addresses below BASE look huge, so one compare covers both ends.
    assign in_range         = (req_addr - BASE) < SIZE;
    assign unused_addr_lsbs = ^in_addr[2:0];

    always_comb begin
        state_d  = state_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        dvld_d   = 1'b0;
        dwen_d   = dwen_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        dmask_d  = dmask_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    wen_d   = in_wen;
                    addr_d  = req_addr;
                    wdata_d = in_wdata;
                    mask_d  = in_mask;
                    rdata_d = '0;
                    err_d   = !in_range;
                    if (in_range && (in_mask[3:0] != 4'h0)) begin
                        state_d  = ISSUE_LO;
                        dvld_d   = 1'b1;
                        dwen_d   = in_wen;
                        daddr_d  = req_addr;
                        dwdata_d = in_wdata[31:0];
                        dmask_d  = in_mask[3:0];
                    end else if (in_range && (in_mask[7:4] != 4'h0)) begin
                        state_d  = ISSUE_HI;
                        dvld_d   = 1'b1;
                        dwen_d   = in_wen;
                        daddr_d  = req_addr + 32'd4;
                        dwdata_d = in_wdata[63:32];
                        dmask_d  = in_mask[7:4];
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            ISSUE_LO: state_d = CAPT_LO;
            ISSUE_HI: state_d = CAPT_HI;
            CAPT_LO: begin
                // Write responses are sampled but discarded so out_rdata stays zero.
                rdata_d[31:0] = wen_q ? '0 : dev_resp_rdata;
                if (mask_q[7:4] != 4'h0) begin
                    state_d  = ISSUE_HI;
                    dvld_d   = 1'b1;
                    dwen_d   = wen_q;
                    daddr_d  = addr_q + 32'd4;
                    dwdata_d = wdata_q[63:32];
                    dmask_d  = mask_q[7:4];
                end else begin
                    state_d = RESP;
                end
            end
            CAPT_HI: begin
                rdata_d[63:32] = wen_q ? '0 : dev_resp_rdata;
                state_d        = RESP;
            end
            RESP: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            dvld_q   <= 1'b0;
            dwen_q   <= 1'b0;
            daddr_q  <= '0;
            dwdata_q <= '0;
            dmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            dvld_q   <= dvld_d;
            dwen_q   <= dwen_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            dmask_q  <= dmask_d;
        end
    end

    assign in_ready      = rst_n && (state_q == IDLE);
    assign out_valid     = (state_q == RESP);
    assign out_rdata     = rdata_q;
    assign out_err       = err_q;
    assign dev_req_valid = dvld_q;
    assign dev_req_wen   = dwen_q;
    assign dev_req_addr  = daddr_q;
    assign dev_req_wdata = dwdata_q;
    assign dev_req_wmask = dmask_q;

endmodule

// File: tb/tb_device_req_bridge.sv
// Directed bench for device_req_bridge with a tiny inline device responder.
module tb_device_req_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_wen;
    logic [31:0] in_addr;
    logic [63:0] in_wdata;
    logic [7:0]  in_mask;
    logic        out_valid, out_ready, out_err;
    logic [63:0] out_rdata;
    logic        dev_req_valid, dev_req_wen;
    logic [31:0] dev_req_addr, dev_req_wdata, dev_resp_rdata;
    logic [3:0]  dev_req_wmask;

    int errors = 0;
    int checks = 0;

    logic [31:0] resp_lo, resp_hi;
    int          n_dev;
    logic [31:0] log_addr[4];
    logic [31:0] log_wdata[4];
    logic [3:0]  log_mask[4];
    logic        log_wen[4];

    always #5 clk = ~clk;

    device_req_bridge dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wen        (in_wen),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_mask       (in_mask),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_err       (out_err),
        .dev_req_valid (dev_req_valid),
        .dev_req_wen   (dev_req_wen),
        .dev_req_addr  (dev_req_addr),
        .dev_req_wdata (dev_req_wdata),
        .dev_req_wmask (dev_req_wmask),
        .dev_resp_rdata(dev_resp_rdata)
    );

    // Advance one cycle; log any device transaction and present its read data.
    task automatic step();
        @(posedge clk);
        #1;
        if (dev_req_valid) begin
            if (n_dev < 4) begin
                log_addr[n_dev]  = dev_req_addr;
                log_wdata[n_dev] = dev_req_wdata;
                log_mask[n_dev]  = dev_req_wmask;
                log_wen[n_dev]   = dev_req_wen;
            end
            n_dev++;
            dev_resp_rdata = dev_req_addr[2] ? resp_hi : resp_lo;
        end
    endtask

    // Present a request, accept it, and return at the first out_valid cycle.
    task automatic send(input logic wen, input logic [31:0] addr, input logic [63:0] wd,
                        input logic [7:0] m, output int lat);
        n_dev    = 0;
        in_wen   = wen;
        in_addr  = addr;
        in_wdata = wd;
        in_mask  = m;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_during_resp: in_ready=%b want 0", in_ready);
        end
    endtask

    task automatic release_resp();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({in_ready, out_valid, out_err, dev_req_valid, dev_req_wen} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready/ovld/err/dvld/dwen=%b want 00000",
                     {in_ready, out_valid, out_err, dev_req_valid, dev_req_wen});
        end
        checks++;
        if (out_rdata !== 64'h0 || dev_req_addr !== 32'h0 || dev_req_wdata !== 32'h0 ||
            dev_req_wmask !== 4'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h daddr=%h dwdata=%h dmask=%h want all 0",
                     out_rdata, dev_req_addr, dev_req_wdata, dev_req_wmask);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_read_both();
        int lat;
        resp_lo = 32'h1111_1111;
        resp_hi = 32'h2222_2222;
        send(1'b0, 32'h4000_0010, 64'h0, 8'hFF, lat);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL both_latency: got %0d want 5", lat);
        end
        checks++;
        if (n_dev != 2 || log_addr[0] !== 32'h4000_0010 || log_addr[1] !== 32'h4000_0014) begin
            errors++;
            $display("FAIL both_dev_addr: n=%0d a0=%h a1=%h want 2 40000010 40000014",
                     n_dev, log_addr[0], log_addr[1]);
        end
        checks++;
        if (log_wen[0] !== 1'b0 || log_wen[1] !== 1'b0 || log_mask[0] !== 4'hF ||
            log_mask[1] !== 4'hF) begin
            errors++;
            $display("FAIL both_dev_ctl: wen=%b%b mask=%h%h want 00 FF",
                     log_wen[0], log_wen[1], log_mask[0], log_mask[1]);
        end
        checks++;
        if (out_rdata !== 64'h2222_2222_1111_1111 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL both_rdata: rdata=%h err=%b want 2222222211111111 0",
                     out_rdata, out_err);
        end
        release_resp();
    endtask

    task automatic test_write_hi();
        int lat;
        resp_lo = 32'h5555_5555;
        resp_hi = 32'h6666_6666;
        send(1'b1, 32'h4000_0008, 64'hAABB_CCDD_0000_0000, 8'hF0, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL whi_latency: got %0d want 3", lat);
        end
        checks++;
        if (n_dev != 1 || log_addr[0] !== 32'h4000_000C || log_wdata[0] !== 32'hAABB_CCDD ||
            log_mask[0] !== 4'hF || log_wen[0] !== 1'b1) begin
            errors++;
            $display("FAIL whi_dev: n=%0d a=%h wd=%h m=%h wen=%b want 1 4000000c aabbccdd f 1",
                     n_dev, log_addr[0], log_wdata[0], log_mask[0], log_wen[0]);
        end
        checks++;
        if (out_rdata !== 64'h0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL whi_resp: rdata=%h err=%b want 0 0", out_rdata, out_err);
        end
        release_resp();
    endtask

    task automatic test_window_edges();
        int lat;
        resp_lo = 32'hCAFE_F00D;
        resp_hi = 32'hDEAD_BEEF;
        send(1'b0, 32'h3FFF_FFF8, 64'h0, 8'hFF, lat);
        checks++;
        if (lat != 1 || n_dev != 0 || out_err !== 1'b1 || out_rdata !== 64'h0) begin
            errors++;
            $display("FAIL below_base: lat=%0d n=%0d err=%b rdata=%h want 1 0 1 0",
                     lat, n_dev, out_err, out_rdata);
        end
        release_resp();
        send(1'b0, 32'h5000_0000, 64'h0, 8'h0F, lat);
        checks++;
        if (lat != 1 || n_dev != 0 || out_err !== 1'b1 || out_rdata !== 64'h0) begin
            errors++;
            $display("FAIL at_limit: lat=%0d n=%0d err=%b rdata=%h want 1 0 1 0",
                     lat, n_dev, out_err, out_rdata);
        end
        release_resp();
        // Last word of the window, low bits of the address ignored.
        send(1'b0, 32'h4FFF_FFFC, 64'h0, 8'h0F, lat);
        checks++;
        if (lat != 3 || n_dev != 1 || log_addr[0] !== 32'h4FFF_FFF8 || out_err !== 1'b0 ||
            out_rdata !== 64'h0000_0000_CAFE_F00D) begin
            errors++;
            $display("FAIL last_word: lat=%0d n=%0d a=%h err=%b rdata=%h want 3 1 4ffffff8 0 00000000cafef00d",
                     lat, n_dev, log_addr[0], out_err, out_rdata);
        end
        release_resp();
    endtask

    task automatic test_zero_mask();
        int lat;
        send(1'b0, 32'h4000_0040, 64'h0, 8'h00, lat);
        checks++;
        if (lat != 1 || n_dev != 0 || out_err !== 1'b0 || out_rdata !== 64'h0) begin
            errors++;
            $display("FAIL zero_mask: lat=%0d n=%0d err=%b rdata=%h want 1 0 0 0",
                     lat, n_dev, out_err, out_rdata);
        end
        release_resp();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_to_idle: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_stall();
        int lat;
        resp_lo = 32'h1234_5678;
        resp_hi = 32'h9ABC_DEF0;
        send(1'b0, 32'h4000_0030, 64'h0, 8'h0F, lat);
        n_dev = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_err !== 1'b0 ||
                out_rdata !== 64'h0000_0000_1234_5678 || n_dev != 0) begin
                errors++;
                $display("FAIL stall_%0d: ovld=%b rdy=%b err=%b rdata=%h ndev=%0d want 1 0 0 0000000012345678 0",
                         i, out_valid, in_ready, out_err, out_rdata, n_dev);
            end
        end
        release_resp();
    endtask

    task automatic test_reset_mid();
        int lat;
        resp_lo = 32'h0BAD_0001;
        resp_hi = 32'h0BAD_0002;
        n_dev    = 0;
        in_wen   = 1'b0;
        in_addr  = 32'h4000_0020;
        in_wdata = 64'h0;
        in_mask  = 8'hFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if (dev_req_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: dvld=%b ovld=%b rdy=%b want 0 0 0",
                     dev_req_valid, out_valid, in_ready);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (n_dev != 1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: ndev=%0d ovld=%b rdy=%b want 1 0 1", n_dev, out_valid, in_ready);
        end
        resp_lo = 32'h7777_0000;
        resp_hi = 32'h0000_8888;
        send(1'b0, 32'h4000_0020, 64'h0, 8'hFF, lat);
        checks++;
        if (lat != 5 || n_dev != 2 || out_rdata !== 64'h0000_8888_7777_0000) begin
            errors++;
            $display("FAIL mid_next: lat=%0d n=%0d rdata=%h want 5 2 0000888877770000",
                     lat, n_dev, out_rdata);
        end
        release_resp();
    endtask

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_wen         = 1'b0;
        in_addr        = '0;
        in_wdata       = '0;
        in_mask        = '0;
        out_ready      = 1'b0;
        dev_resp_rdata = '0;
        resp_lo        = '0;
        resp_hi        = '0;
        n_dev          = 0;
        for (int i = 0; i < 4; i++) begin
            log_addr[i]  = '0;
            log_wdata[i] = '0;
            log_mask[i]  = '0;
            log_wen[i]   = 1'b0;
        end
        test_reset();
        test_read_both();
        test_write_hi();
        test_window_edges();
        test_zero_mask();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
